mac_result_writer: RTL and testbench

Avalon-MM write master that stores the matrix-vector MAC results back into memory, the write-side counterpart of the fetch path that loads the operands. It sits beside `mat_vec_mult` and is kicked off when compute finishes. It snapshots all results and writes one per word to consecutive addresses, honouring `waitrequest`. It exposes a small state code for LEDs and a sticky done.

---
 rtl/mac_writer_pkg.sv | 13 +
 rtl/avmm_write_port.sv | 38 +++
 rtl/mac_result_writer.sv | 102 ++++++++++
 tb/tb_mac_result_writer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mac_writer_pkg.sv
// mac_writer_pkg: shared state encoding and default sizes for the MAC result writer.
package mac_writer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } writer_state_t;
  localparam int DEF_NUM_RESULTS = 8;
  localparam int DEF_RESULT_W    = 24;
  localparam int DEF_DATA_W      = 64;
  localparam int DEF_ADDR_W      = 32;
endpackage

// File: rtl/avmm_write_port.sv
// avmm_write_port: registered Avalon-MM write beat that holds address/data/write while stalled.
module avmm_write_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              waitrequest_i,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] writedata_o,
  output logic              write_o,
  output logic              beat_accepted_o
);
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;
  // A new beat may only replace the current one once the slave has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else if (!write_q || !waitrequest_i) begin
      write_q <= load_i;
      if (load_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end
  assign address_o       = addr_q;
  assign writedata_o     = data_q;
  assign write_o         = write_q;
  assign beat_accepted_o = write_q & ~waitrequest_i;
endmodule

// File: rtl/mac_result_writer.sv
// mac_result_writer: snapshots MAC results and writes them as consecutive Avalon-MM words.
// Define MAC_RESULT_WRITER_CHECKSUM_EN to append a sum-of-results beat at BASE_ADDR+NUM_RESULTS.
module mac_result_writer
  import mac_writer_pkg::*;
#(
  parameter int                NUM_RESULTS = DEF_NUM_RESULTS,
  parameter int                RESULT_W    = DEF_RESULT_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_RESULTS*RESULT_W-1:0] results,
  output logic [ADDR_W-1:0]               address,
  output logic                            write,
  output logic [DATA_W-1:0]               writedata,
  input  logic                            waitrequest,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      state
);
`ifdef MAC_RESULT_WRITER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int NUM_BEATS = NUM_RESULTS + CSUM;
  localparam int IDX_W     = $clog2(NUM_BEATS + 1);
  writer_state_t                   state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d, nxt_idx;
  logic [NUM_RESULTS*RESULT_W-1:0] snap_q, snap_d, src;
  logic [DATA_W-1:0]               nxt_data;
  logic                            load, last, beat_accepted;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end
  // The first beat is loaded on the capture edge, so it reads the live inputs.
  assign nxt_idx = (state_q == CAPTURE) ? '0 : idx_q + IDX_W'(1);
  assign src     = (state_q == CAPTURE) ? results : snap_q;
  assign last    = idx_q == IDX_W'(NUM_BEATS - 1);
`ifdef MAC_RESULT_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_RESULTS; i++) csum = csum + DATA_W'(snap_q[i*RESULT_W +: RESULT_W]);
  end
`endif
  always_comb begin
    nxt_data = '0;
    for (int i = 0; i < NUM_RESULTS; i++)
      if (nxt_idx == IDX_W'(i)) nxt_data = DATA_W'(src[i*RESULT_W +: RESULT_W]);
`ifdef MAC_RESULT_WRITER_CHECKSUM_EN
    if (nxt_idx == IDX_W'(NUM_RESULTS)) nxt_data = csum;
`endif
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: state_d = start ? CAPTURE : state_q;
      CAPTURE: begin
        snap_d  = results;
        idx_d   = '0;
        load    = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (beat_accepted) begin
        idx_d   = nxt_idx;
        load    = !last;
        state_d = last ? DONE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  avmm_write_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load),
    .addr_i         (BASE_ADDR + ADDR_W'(nxt_idx)),
    .data_i         (nxt_data),
    .waitrequest_i  (waitrequest),
    .address_o      (address),
    .writedata_o    (writedata),
    .write_o        (write),
    .beat_accepted_o(beat_accepted)
  );
  assign state = state_q;
  assign busy  = (state_q == CAPTURE) || (state_q == WRITE);
  assign done  = state_q == DONE;
endmodule

// File: tb/tb_mac_result_writer.sv
// tb_mac_result_writer: directed checks of beat order, stalls, snapshot, reset abort and restart.
module tb_mac_result_writer;
`ifdef MAC_RESULT_WRITER_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic          clk = 1'b0;
  logic          rst, start, waitrequest, write, busy, done;
  logic [191:0]  results;
  logic [31:0]   address;
  logic [63:0]   writedata;
  logic [1:0]    state;
  logic [23:0]   exp_r [8];
  int            stall_cfg [9];
  int            nbeats, stall_left, checks, errors;

  mac_result_writer dut (
    .clk(clk), .rst(rst), .start(start), .results(results), .address(address),
    .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int k);
    logic [63:0] s = '0;
    if (k < 8) return {40'b0, exp_r[k]};
    for (int i = 0; i < 8; i++) s += {40'b0, exp_r[i]};
    return s;
  endfunction

  // Slave model: stalls per stall_cfg and logs every accepted beat.
  always @(negedge clk) begin
    if (write) begin
      if (stall_left > 0) begin
        waitrequest = 1'b1;
        stall_left--;
        check("stall_addr", {32'b0, address}, 64'(nbeats));
        check("stall_data", writedata, exp_beat(nbeats));
      end else begin
        waitrequest = 1'b0;
        check("beat_addr", {32'b0, address}, 64'(nbeats));
        check("beat_data", writedata, exp_beat(nbeats));
        nbeats++;
        stall_left = (nbeats < 9) ? stall_cfg[nbeats] : 0;
      end
    end else waitrequest = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_results();
    for (int i = 0; i < 8; i++) results[i*24 +: 24] = exp_r[i];
  endtask

  task automatic run(input string tag, input int exp_lat, input bit snap_change, input bit glitch);
    int cyc = 0;
    nbeats = 0;
    stall_left = stall_cfg[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_capture"}, 64'(state), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        check({tag, "_first_write"}, 64'(write), 64'd1);
        check({tag, "_write_state"}, 64'(state), 64'd2);
      end
      if (snap_change && cyc == 1) results = {8{24'hFFFFFF}};
      start = glitch && (cyc == 3 || cyc == 5);
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_beats"}, 64'(nbeats), 64'(NB));
    check({tag, "_state_done"}, 64'(state), 64'd3);
    check({tag, "_write_dropped"}, 64'(write), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    tick();
    tick();
    check({tag, "_sticky"}, 64'(done), 64'd1);
    check({tag, "_no_extra"}, 64'(nbeats), 64'(NB));
  endtask

  initial begin
    int w;
    checks = 0;
    errors = 0;
    nbeats = 0;
    stall_left = 0;
    rst = 1'b1;
    start = 1'b0;
    waitrequest = 1'b0;
    for (int i = 0; i < 9; i++) stall_cfg[i] = 0;
    for (int i = 0; i < 8; i++) exp_r[i] = 24'h0012CC + 24'(i) * 24'h004240;
    set_results();
    tick();
    tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_address", {32'b0, address}, 64'd0);
    check("rst_writedata", writedata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_hold", 64'(state), 64'd0);
`ifdef MAC_RESULT_WRITER_CHECKSUM_EN
    check("csum_value", exp_beat(8), 64'h000000000007D560);
`endif
    run("directed", NB + 1, 1'b0, 1'b0);
    stall_cfg[2] = 3;
    stall_cfg[5] = 1;
    run("stall", NB + 5, 1'b0, 1'b0);
    stall_cfg[2] = 0;
    stall_cfg[5] = 0;
    run("snapshot", NB + 1, 1'b1, 1'b0);
    set_results();
    nbeats = 0;
    stall_left = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (nbeats < 4 && w < 50) begin
      tick();
      w++;
    end
    check("reach_beat4", 64'(nbeats), 64'd4);
    check("beat4_present", 64'(write), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_write", 64'(write), 64'd0);
    check("abort_state", 64'(state), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run("after_reset", NB + 1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) exp_r[i] = 24'hA00001 + 24'(i) * 24'h010203;
    set_results();
    run("restart", NB + 1, 1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
